// File: rtl/cordic_loader_pkg.sv
// Shared types and default widths for the CORDIC data-memory input loader.
package cordic_loader_pkg;

    typedef enum logic [0:0] {
        ENTRY = 1'b0,
        WRITE = 1'b1
    } loader_state_e;

    localparam int LOADER_ADDR_W = 8;
    localparam int LOADER_DATA_W = 32;
    localparam int NIBBLE_W      = 4;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one raw active-low push-button.
// It emits a one-cycle pulse on each accepted press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic stable,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer, stability counter and press-edge detection.
    // The pulse comes from the delayed stable copy, so it lands one cycle after stable falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            stable_r   <= 1'b1;
            stable_d_r <= 1'b1;
            press_r    <= 1'b0;
            cnt_r      <= '0;
        end else begin
            sync1_r    <= key_n;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_d_r & ~stable_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign stable      = stable_r;
    assign press_pulse = press_r;

endmodule

// File: rtl/cordic_input_loader.sv
// Assembles a word from switch nibbles using two debounced keys.
// It writes the word to CORDIC data memory over a valid/ready port.
module cordic_input_loader
    import cordic_loader_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 1000000,
    parameter  int ADDR_W          = LOADER_ADDR_W,
    parameter  int DATA_W          = LOADER_DATA_W,
    localparam int NIBBLES         = DATA_W / NIBBLE_W,
    localparam int NC_W            = $clog2(NIBBLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_enter_n,
    input  logic                key_commit_n,
    input  logic [NIBBLE_W-1:0] sw_data,
    input  logic [ADDR_W-1:0]   sw_addr,
    input  logic                addr_from_sw,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   staging,
    output logic [NC_W-1:0]     nib_count,
    output logic [ADDR_W-1:0]   next_addr
);

    logic enter_pulse_s;
    logic commit_pulse_s;

    loader_state_e     state_r,     state_nx;
    logic [DATA_W-1:0] staging_r,   staging_nx;
    logic [NC_W-1:0]   nib_count_r, nib_count_nx;
    logic [ADDR_W-1:0] next_addr_r, next_addr_nx;
    logic              wr_valid_r,  wr_valid_nx;
    logic [ADDR_W-1:0] wr_addr_r,   wr_addr_nx;
    logic [DATA_W-1:0] wr_data_r,   wr_data_nx;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_enter_n),
        .stable      (),
        .press_pulse (enter_pulse_s)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_db (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_commit_n),
        .stable      (),
        .press_pulse (commit_pulse_s)
    );

    // Next-state and datapath updates; a commit takes priority over a same-cycle enter.
    always_comb begin
        state_nx     = state_r;
        staging_nx   = staging_r;
        nib_count_nx = nib_count_r;
        next_addr_nx = next_addr_r;
        wr_valid_nx  = wr_valid_r;
        wr_addr_nx   = wr_addr_r;
        wr_data_nx   = wr_data_r;
        case (state_r)
            ENTRY: begin
                if (commit_pulse_s && (nib_count_r != '0)) begin
                    wr_data_nx  = staging_r;
                    wr_addr_nx  = addr_from_sw ? sw_addr : next_addr_r;
                    wr_valid_nx = 1'b1;
                    state_nx    = WRITE;
                end else if (enter_pulse_s) begin
                    staging_nx   = {staging_r[DATA_W-NIBBLE_W-1:0], sw_data};
                    nib_count_nx = (nib_count_r == NC_W'(NIBBLES)) ? nib_count_r
                                                                   : nib_count_r + NC_W'(1);
                end else begin
                    state_nx = ENTRY;
                end
            end
            WRITE: begin
                if (wr_valid_r && wr_ready) begin
                    wr_valid_nx  = 1'b0;
                    staging_nx   = '0;
                    nib_count_nx = '0;
                    next_addr_nx = wr_addr_r + ADDR_W'(1);
                    state_nx     = ENTRY;
                end else begin
                    state_nx = WRITE;
                end
            end
            default: begin
                state_nx    = ENTRY;
                wr_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ENTRY;
            staging_r   <= '0;
            nib_count_r <= '0;
            next_addr_r <= '0;
            wr_valid_r  <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
        end else begin
            state_r     <= state_nx;
            staging_r   <= staging_nx;
            nib_count_r <= nib_count_nx;
            next_addr_r <= next_addr_nx;
            wr_valid_r  <= wr_valid_nx;
            wr_addr_r   <= wr_addr_nx;
            wr_data_r   <= wr_data_nx;
        end
    end

    assign wr_valid  = wr_valid_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign staging   = staging_r;
    assign nib_count = nib_count_r;
    assign next_addr = next_addr_r;

endmodule

// File: tb/tb_cordic_input_loader.sv
// Directed bench for cordic_input_loader.
// It uses a short debounce window, a table of nibble entries and hand-written corner sequences.
module tb_cordic_input_loader;
    import cordic_loader_pkg::*;

    localparam int DB  = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int NCW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_enter_n = 1'b1;
    logic          key_commit_n = 1'b1;
    logic [3:0]    sw_data = 4'h0;
    logic [AW-1:0] sw_addr = 8'h00;
    logic          addr_from_sw = 1'b0;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] staging;
    logic [NCW-1:0] nib_count;
    logic [AW-1:0] next_addr;

    cordic_input_loader #(.DEBOUNCE_CYCLES(DB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_enter_n  (key_enter_n),
        .key_commit_n (key_commit_n),
        .sw_data      (sw_data),
        .sw_addr      (sw_addr),
        .addr_from_sw (addr_from_sw),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .staging      (staging),
        .nib_count    (nib_count),
        .next_addr    (next_addr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Write monitor: counts valid cycles and completed handshakes.
    int            write_cnt = 0;
    int            valid_cycles = 0;
    logic [AW-1:0] last_addr = 8'h00;
    logic [DW-1:0] last_data = 32'h0;
    logic [DW-1:0] last_stg = 32'h0;

    always @(posedge clk) begin
        if (wr_valid) valid_cycles++;
        if (wr_valid && wr_ready) begin
            write_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
            last_stg  = staging;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic press(input bit en, input bit cm);
        @(negedge clk);
        if (en) key_enter_n = 1'b0;
        if (cm) key_commit_n = 1'b0;
        repeat (10) @(negedge clk);
        key_enter_n  = 1'b1;
        key_commit_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]    nib;
        logic [DW-1:0] exp_stg;
        logic [NCW-1:0] exp_cnt;
        bit            commit;
        bit            use_sw;
        logic [AW-1:0] sw_a;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_next;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [3:0] nib, input logic [DW-1:0] stg,
                                input logic [NCW-1:0] cnt);
        vec_t v;
        v.nib = nib; v.exp_stg = stg; v.exp_cnt = cnt;
        v.commit = 1'b0; v.use_sw = 1'b0; v.sw_a = 8'h00;
        v.exp_addr = 8'h00; v.exp_data = 32'h0; v.exp_next = 8'h00;
        return v;
    endfunction

    initial begin
        int wc;
        int vc;
        bit ok;
        bit bad;

        tbl[0]  = mk(4'h1, 32'h00000001, 4'd1);
        tbl[1]  = mk(4'h2, 32'h00000012, 4'd2);
        tbl[2]  = mk(4'h3, 32'h00000123, 4'd3);
        tbl[3]  = mk(4'h4, 32'h00001234, 4'd4);
        tbl[4]  = mk(4'h5, 32'h00012345, 4'd5);
        tbl[5]  = mk(4'h6, 32'h00123456, 4'd6);
        tbl[6]  = mk(4'h7, 32'h01234567, 4'd7);
        tbl[7]  = mk(4'h8, 32'h12345678, 4'd8);
        tbl[7].commit = 1'b1; tbl[7].use_sw = 1'b0; tbl[7].sw_a = 8'h5A;
        tbl[7].exp_addr = 8'h00; tbl[7].exp_data = 32'h12345678; tbl[7].exp_next = 8'h01;
        tbl[8]  = mk(4'h1, 32'h00000001, 4'd1);
        tbl[9]  = mk(4'h2, 32'h00000012, 4'd2);
        tbl[10] = mk(4'h3, 32'h00000123, 4'd3);
        tbl[11] = mk(4'h4, 32'h00001234, 4'd4);
        tbl[12] = mk(4'h5, 32'h00012345, 4'd5);
        tbl[13] = mk(4'h6, 32'h00123456, 4'd6);
        tbl[14] = mk(4'h7, 32'h01234567, 4'd7);
        tbl[15] = mk(4'h8, 32'h12345678, 4'd8);
        tbl[16] = mk(4'h9, 32'h23456789, 4'd8);
        tbl[16].commit = 1'b1; tbl[16].use_sw = 1'b1; tbl[16].sw_a = 8'hFF;
        tbl[16].exp_addr = 8'hFF; tbl[16].exp_data = 32'h23456789; tbl[16].exp_next = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_staging", staging, 32'h0);
        chk("rst_nib_count", {28'h0, nib_count}, 32'h0);
        chk("rst_next_addr", {24'h0, next_addr}, 32'h0);
        chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);

        // Glitch of three cycles, shorter than the debounce window
        key_enter_n = 1'b0;
        repeat (3) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_staging", staging, 32'h0);
        chk("glitch_nib_count", {28'h0, nib_count}, 32'h0);

        // Table: nibble entry with commits to the pointer and to sw_addr 0xFF
        for (int i = 0; i < 17; i++) begin
            sw_data = tbl[i].nib;
            press(1'b1, 1'b0);
            chk("tbl_staging", staging, tbl[i].exp_stg);
            chk("tbl_nib_count", {28'h0, nib_count}, {28'h0, tbl[i].exp_cnt});
            if (tbl[i].commit) begin
                wc = write_cnt;
                addr_from_sw = tbl[i].use_sw;
                sw_addr = tbl[i].sw_a;
                press(1'b0, 1'b1);
                chk("tbl_write_count", write_cnt - wc, 32'd1);
                chk("tbl_wr_addr", {24'h0, last_addr}, {24'h0, tbl[i].exp_addr});
                chk("tbl_wr_data", last_data, tbl[i].exp_data);
                chk("tbl_next_addr", {24'h0, next_addr}, {24'h0, tbl[i].exp_next});
                chk("tbl_post_staging", staging, 32'h0);
                chk("tbl_post_nib_count", {28'h0, nib_count}, 32'h0);
                addr_from_sw = 1'b0;
            end
        end

        // A commit with no nibbles entered is ignored
        vc = valid_cycles;
        press(1'b0, 1'b1);
        chk("empty_commit_valid_cycles", valid_cycles - vc, 32'd0);
        chk("empty_commit_wr_valid", {31'h0, wr_valid}, 32'h0);

        // Simultaneous enter and commit: commit wins and the enter is dropped
        sw_data = 4'hA;
        press(1'b1, 1'b0);
        chk("simul_pre_staging", staging, 32'h0000000A);
        sw_data = 4'h5;
        wc = write_cnt;
        press(1'b1, 1'b1);
        chk("simul_write_count", write_cnt - wc, 32'd1);
        chk("simul_wr_data", last_data, 32'h0000000A);
        chk("simul_staging_at_write", last_stg, 32'h0000000A);
        chk("simul_wr_addr", {24'h0, last_addr}, 32'h0);
        chk("simul_next_addr", {24'h0, next_addr}, 32'h1);

        // Backpressure: hold wr_ready low for 10 cycles, with an enter press during the stall
        wr_ready = 1'b0;
        sw_data = 4'h3;
        press(1'b1, 1'b0);
        chk("stall_pre_staging", staging, 32'h3);
        key_commit_n = 1'b0;
        wait_valid(ok);
        chk("stall_valid_rise", {31'h0, ok}, 32'h1);
        key_commit_n = 1'b1;
        key_enter_n = 1'b0;
        sw_data = 4'hC;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_valid !== 1'b1 || wr_addr !== 8'h01 || wr_data !== 32'h3) bad = 1'b1;
        end
        chk("stall_hold", {31'h0, bad}, 32'h0);
        chk("stall_staging", staging, 32'h3);
        chk("stall_nib_count", {28'h0, nib_count}, 32'h1);
        wc = write_cnt;
        wr_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", {31'h0, wr_valid}, 32'h0);
        chk("stall_write_count", write_cnt - wc, 32'd1);
        chk("stall_wr_addr", {24'h0, last_addr}, 32'h1);
        chk("stall_wr_data", last_data, 32'h3);
        chk("stall_next_addr", {24'h0, next_addr}, 32'h2);
        key_enter_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("stall_post_staging", staging, 32'h0);

        // Reset in the middle of a stalled write
        wr_ready = 1'b0;
        sw_data = 4'h7;
        press(1'b1, 1'b0);
        key_commit_n = 1'b0;
        wait_valid(ok);
        chk("rstw_valid_rise", {31'h0, ok}, 32'h1);
        key_commit_n = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("rstw_state", {31'h0, dut.state_r == ENTRY}, 32'h1);
        chk("rstw_next_addr", {24'h0, next_addr}, 32'h0);
        chk("rstw_staging", staging, 32'h0);
        rst = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
